// File: rtl/fetch_controller.sv
// fetch_controller: IF-stage fetch sequencer.
// Owns the fetch PC, drives a combinational-read instruction memory, and
// registers each fetched word with its PC into a valid/ready slot for decode.
// Handles decode back-pressure and branch/jump redirects.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   -> a misaligned redirect halts fetch and raises a sticky trap
//   undefined -> misaligned redirect targets are forced to word alignment
module fetch_controller #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_instr,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc,
    output logic            misalign_trap,
    output logic [XLEN-1:0] trap_pc
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // Clears the two byte-offset bits of a word address.
    localparam logic [XLEN-1:0] WORD_MASK = ~{{(XLEN-2){1'b0}}, 2'b11};

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] opc_q, opc_d;

    logic            redirect_bad;
    logic [XLEN-1:0] redirect_target;

    assign redirect_target = redirect_pc & WORD_MASK;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic            trap_q, trap_d;
    logic [XLEN-1:0] tpc_q, tpc_d;

    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Sticky trap flag: set by a misaligned redirect, cleared by an aligned one.
    always_comb begin
        trap_d = trap_q;
        tpc_d  = tpc_q;
        if (redirect_valid) begin
            if (redirect_bad) begin
                trap_d = 1'b1;
                tpc_d  = redirect_pc;
            end else begin
                trap_d = 1'b0;
            end
        end
    end

    // Trap flag and offending address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            tpc_q  <= '0;
        end else begin
            trap_q <= trap_d;
            tpc_q  <= tpc_d;
        end
    end

    assign misalign_trap = trap_q;
    assign trap_pc       = tpc_q;
`else
    // Misaligned targets are silently aligned, so a redirect never halts.
    assign redirect_bad  = 1'b0;
    assign misalign_trap = 1'b0;
    assign trap_pc       = '0;
`endif

    // Next-state logic: a redirect outranks everything, then stall, then fetch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        instr_d = instr_q;
        opc_d   = opc_q;
        if (redirect_valid) begin
            // Any held instruction is dropped; the new PC is fetched next cycle.
            valid_d = 1'b0;
            if (redirect_bad) begin
                state_d = ST_HALT;
            end else begin
                state_d = ST_RUN;
                pc_d    = redirect_target;
            end
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Capture unless decode is refusing a held slot.
                    if (!(valid_q && !out_ready)) begin
                        instr_d = imem_instr;
                        opc_d   = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                    end
                end
                ST_HALT: begin
                    valid_d = 1'b0;
                end
                default: begin
                    state_d = ST_BOOT;
                    valid_d = 1'b0;
                end
            endcase
        end
    end

    // State, PC and output-slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            opc_q   <= opc_d;
        end
    end

    assign imem_addr = pc_q & WORD_MASK;
    assign out_valid = valid_q;
    assign out_instr = instr_q;
    assign out_pc    = opc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Testbench for fetch_controller: directed scenarios plus a randomized run
// checked against a behavioural model of the fetch stream.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_trap;
    logic [31:0] trap_pc;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    // Instruction memory: word at address A is A ^ 0xA5 (low address bits ignored).
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[31:2], 2'b00} ^ 32'hA5;
    endfunction

    assign imem_instr = mem_word(imem_addr);

    fetch_controller #(.XLEN(32), .RESET_PC(32'h100)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .misalign_trap  (misalign_trap),
        .trap_pc        (trap_pc)
    );

    // Behavioural model: next fetch address, the slot contents and trap status.
    bit          m_booting;
    bit          m_halted;
    logic [31:0] m_pc;
    bit          m_valid;
    logic [31:0] m_instr;
    logic [31:0] m_opc;
    bit          m_trap;
    logic [31:0] m_tpc;

    task automatic model_reset();
        m_booting = 1; m_halted = 0; m_pc = 32'h100;
        m_valid = 0; m_instr = 0; m_opc = 0; m_trap = 0; m_tpc = 0;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_clock();
        if (redirect_valid) begin
            m_valid   = 0;
            m_booting = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (redirect_pc % 4 != 0) begin
                m_halted = 1; m_trap = 1; m_tpc = redirect_pc;
            end else begin
                m_halted = 0; m_trap = 0; m_pc = redirect_pc;
            end
`else
            m_pc = redirect_pc - (redirect_pc % 4);
`endif
        end else if (m_booting) begin
            m_booting = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (!m_valid || out_ready) begin
            m_instr = mem_word(m_pc);
            m_opc   = m_pc;
            m_valid = 1;
            m_pc    = m_pc + 32'd4;
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b0, 32'h0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_slot: got v=%b pc=%h i=%h want v=0 pc=0 i=0", out_valid, out_pc, out_instr);
        end
        tests_run++;
        if ({imem_addr, misalign_trap, trap_pc} !== {32'h100, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL reset_pc_trap: got addr=%h trap=%b tpc=%h want 100/0/0", imem_addr, misalign_trap, trap_pc);
        end
        $display("[TB] reset: addr=%h out_valid=%b", imem_addr, out_valid);
        rst_n = 1'b1;
    endtask

    task automatic test_boot_stream();
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL boot_bubble: got out_valid=%b want 0", out_valid);
        end
        for (int k = 0; k < 3; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h100 + 32'(4 * k);
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, exp_pc ^ 32'hA5}) begin
                tests_failed++;
                $display("FAIL boot_stream: got v=%b pc=%h i=%h want v=1 pc=%h i=%h",
                         out_valid, out_pc, out_instr, exp_pc, exp_pc ^ 32'hA5);
            end
            $display("[TB] stream: pc=%h instr=%h", out_pc, out_instr);
        end
    endtask

    task automatic test_stall();
        redirect_valid = 1'b1; redirect_pc = 32'h100;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b1, 32'h104, 32'h104 ^ 32'hA5, 32'h108}) begin
                tests_failed++;
                $display("FAIL stall_hold: got v=%b pc=%h i=%h addr=%h want 1/104/%h/108",
                         out_valid, out_pc, out_instr, imem_addr, 32'h104 ^ 32'hA5);
            end
            $display("[TB] stall: pc=%h addr=%h", out_pc, imem_addr);
        end
        out_ready = 1'b1;
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h108, 32'h108 ^ 32'hA5}) begin
            tests_failed++;
            $display("FAIL stall_release: got v=%b pc=%h i=%h want 1/108", out_valid, out_pc, out_instr);
        end
        tick();
        tests_run++;
        if (out_pc !== 32'h10C) begin
            tests_failed++;
            $display("FAIL stall_next: got pc=%h want 10c", out_pc);
        end
        $display("[TB] release: pc=%h", out_pc);
    endtask

    task automatic test_redirect_flush();
        out_ready = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h200;
        tick();
        redirect_valid = 1'b0; out_ready = 1'b1;
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_drop: got out_valid=%b want 0", out_valid);
        end
        for (int k = 0; k < 2; k++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'h200 + 32'(4 * k);
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, exp_pc, exp_pc ^ 32'hA5}) begin
                tests_failed++;
                $display("FAIL flush_restart: got v=%b pc=%h i=%h want 1/%h", out_valid, out_pc, out_instr, exp_pc);
            end
            $display("[TB] redirect: pc=%h", out_pc);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hFFFF_FFF8; exp_seq[1] = 32'hFFFF_FFFC; exp_seq[2] = 32'h0;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            tests_run++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, exp_seq[k], exp_seq[k] ^ 32'hA5}) begin
                tests_failed++;
                $display("FAIL wrap: got v=%b pc=%h i=%h want 1/%h", out_valid, out_pc, out_instr, exp_seq[k]);
            end
            $display("[TB] wrap: pc=%h", out_pc);
        end
    endtask

    task automatic test_misalign();
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        tick();
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 3; k++) begin
            tests_run++;
            if ({out_valid, misalign_trap, trap_pc} !== {1'b0, 1'b1, 32'h202}) begin
                tests_failed++;
                $display("FAIL misalign_halt: got v=%b trap=%b tpc=%h want 0/1/202", out_valid, misalign_trap, trap_pc);
            end
            tick();
        end
        redirect_valid = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_valid = 1'b0;
        tests_run++;
        if ({out_valid, misalign_trap} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL misalign_clear: got v=%b trap=%b want 0/0", out_valid, misalign_trap);
        end
        tick();
        tests_run++;
        if ({out_valid, out_pc} !== {1'b1, 32'h300}) begin
            tests_failed++;
            $display("FAIL misalign_resume: got v=%b pc=%h want 1/300", out_valid, out_pc);
        end
`else
        tests_run++;
        if ({out_valid, misalign_trap, trap_pc} !== {1'b0, 1'b0, 32'h0}) begin
            tests_failed++;
            $display("FAIL misalign_notrap: got v=%b trap=%b tpc=%h want 0/0/0", out_valid, misalign_trap, trap_pc);
        end
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h200, 32'h200 ^ 32'hA5}) begin
            tests_failed++;
            $display("FAIL misalign_align: got v=%b pc=%h i=%h want 1/200", out_valid, out_pc, out_instr);
        end
`endif
        $display("[TB] misalign: pc=%h trap=%b", out_pc, misalign_trap);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            redirect_valid = ($urandom_range(0, 7) == 0);
            redirect_pc    = $urandom();
            if ($urandom_range(0, 3) != 0) redirect_pc[1:0] = 2'b00;
            out_ready      = ($urandom_range(0, 9) < 7);
            tick();
            tests_run++;
            if (out_valid !== m_valid || imem_addr !== m_pc || misalign_trap !== m_trap || trap_pc !== m_tpc) begin
                tests_failed++;
                $display("FAIL random_ctl[%0d]: got v=%b addr=%h trap=%b tpc=%h want v=%b addr=%h trap=%b tpc=%h",
                         n, out_valid, imem_addr, misalign_trap, trap_pc, m_valid, m_pc, m_trap, m_tpc);
            end
            if (m_valid) begin
                tests_run++;
                if (out_pc !== m_opc || out_instr !== m_instr) begin
                    tests_failed++;
                    $display("FAIL random_slot[%0d]: got pc=%h i=%h want pc=%h i=%h", n, out_pc, out_instr, m_opc, m_instr);
                end
            end
            if (n % 50 == 0) $display("[TB] random %0d: v=%b pc=%h", n, out_valid, out_pc);
        end
        redirect_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_async_reset();
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        tick();
        redirect_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL areset_pre: got out_valid=%b want 1", out_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        tests_run++;
        if ({out_valid, out_pc, imem_addr} !== {1'b0, 32'h0, 32'h100}) begin
            tests_failed++;
            $display("FAIL areset_now: got v=%b pc=%h addr=%h want 0/0/100", out_valid, out_pc, imem_addr);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL areset_boot: got out_valid=%b want 0", out_valid);
        end
        tick();
        tests_run++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h100, 32'h100 ^ 32'hA5}) begin
            tests_failed++;
            $display("FAIL areset_restart: got v=%b pc=%h i=%h want 1/100", out_valid, out_pc, out_instr);
        end
        $display("[TB] async reset: restart pc=%h", out_pc);
    endtask

    initial begin
        test_reset();
        test_boot_stream();
        test_stall();
        test_redirect_flush();
        test_wrap();
        test_misalign();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
